inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage sitting directly upstream of the 4 KB instruction ROM.
//  Owns the PC, drives the ROM's chip-enable and byte address, and captures the returned word.
//  Buffers fetched {pc, inst} pairs in a small prefetch FIFO so fetch runs ahead while decode stalls.
//  Presents the FIFO head to the decode stage with a valid/ready handshake; branch and flush redirect the PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH  4              prefetch entries; power of two, >= 2
//  ROM_AW      12             ROM byte-address width (ROM holds 2**(ROM_AW-2) words)
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous, active-high reset
//  rom_ce           out  1       ROM chip enable; ROM returns 0 when low
//  rom_addr         out  ROM_AW  ROM byte address = pc[ROM_AW-1:0]
//  rom_inst         in   32      ROM read data, combinational from rom_addr/rom_ce
//  branch_flag_i    in   1       redirect request from execute
//  branch_target_i  in   32      branch/jump target byte address
//  flush_i          in   1       pipeline flush (trap/exception); has priority over branch_flag_i
//  new_pc_i         in   32      flush target (trap vector)
//  id_ready_i       in   1       decode accepts head entry this cycle
//  id_valid_o       out  1       head entry valid
//  id_pc_o          out  32      PC of head instruction
//  id_inst_o        out  32      head instruction word
//  id_misalign_o    out  1       head entry came from a misaligned redirect target
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_PC, ce_q<=0, FIFO emptied, misalign_pend<=0.
//    Outputs: rom_ce=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, id_misalign_o=0. rst dominates every other input.
//  - ce_q goes to 1 on the first edge with rst=0. The first fetch occurs in the following cycle.
//    First id_valid_o=1 (id_pc_o=RESET_PC) appears two edges after rst falls.
//  - pop = id_valid_o & id_ready_i.
//  - fetch = ce_q & (!full | pop) & !redirect.
//  - rom_ce = ce_q & (!full | pop) (combinational); rom_addr = pc[ROM_AW-1:0] always.
//  - On fetch: {pc, rom_inst, misalign_pend} is pushed at the edge; pc<=pc+4; misalign_pend<=0.
//  - pc is 32-bit and wraps 32'hFFFF_FFFC -> 0. The ROM aliases every 2**ROM_AW bytes; no range error is raised.
//  - Head outputs are read from registered FIFO storage and are masked to 0 when the FIFO is empty.
//    There is no push->pop bypass: a pushed entry is visible the cycle after its edge.
//  - Full with pop in the same cycle: push and pop both occur and count is unchanged.
//    Full without pop: pc is held, rom_ce=0.
//  - Empty: id_valid_o=0, and id_ready_i is ignored.
//  - redirect = flush_i | branch_flag_i; target = flush_i ? new_pc_i : branch_target_i.
//    At the edge: FIFO cleared (count=0, pointers reset), no push, pop discarded.
//    pc <= {target[31:2],2'b00}; misalign_pend <= |target[1:0].
//  - Redirect latency: redirect in cycle N -> rom_addr=target in N+1 -> id_valid_o=1 with id_pc_o=target in N+2.
//    id_valid_o is 0 during N+1.
//  - Consecutive redirects: the last one wins; each clears the FIFO again.
//  - Redirect while ce_q=0 (right after reset): pc still loads the target.
//  - id_misalign_o accompanies only the first entry after a misaligned redirect.
//    Decode raises the instruction-address-misaligned exception from it.
// STRUCTURE
//  - Shared defines header (existing project defines) holds:
//    ZERO_WORD (32'h0), INST_BUS width (32), INST_ADDR_BUS width (32),
//    RST_ENABLE (1'b1), CHIP_ENABLE/CHIP_DISABLE, and the default RESET_PC.
//  - Sub-module fetch_fifo: synchronous FIFO with parameters WIDTH (65) and DEPTH.
//    Ports: push, pop, clear, full, empty, head. clear has priority over push/pop.
//  - inst_fetch holds the PC/ce_q/misalign_pend registers and the redirect mux.
// TESTING
//  - Reset release, id_ready_i=1, ROM word[i]=32'h1000_0000+i
//    -> id_valid_o rises 2 edges after rst falls.
//    -> id_pc_o 0,4,8,... each cycle; id_inst_o 32'h1000_0000, 32'h1000_0001, ...
//  - id_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH=4 entries held, rom_ce=0, pc=16.
//    Then ready=1 -> pcs 0,4,8,12,16 delivered back-to-back with no bubble.
//  - branch_flag_i=1, branch_target_i=32'h0000_0200 while FIFO is full
//    -> next cycle id_valid_o=0, rom_addr=12'h200.
//    -> following cycle id_pc_o=32'h200; no stale entry is ever popped.
//  - flush_i=1 (new_pc_i=32'h0000_0100) together with branch_flag_i=1 (target 32'h300)
//    -> first delivered id_pc_o=32'h100.
//  - Branch target 32'h0000_0046 -> delivered id_pc_o=32'h44 with id_misalign_o=1.
//    The next entry is 32'h48 with id_misalign_o=0.
//  - rst asserted mid-stream with FIFO half full -> all outputs 0 next cycle.
//    Fetch restarts at RESET_PC.
//    pc reaching 32'hFFFF_FFFC -> next pc 0; rom_addr=12'hFFC, then 12'h000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and payload type for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int unsigned INST_BUS_W      = 32;
    localparam int unsigned INST_ADDR_BUS_W = 32;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        RST_ENABLE       = 1'b1;
    localparam logic        CHIP_ENABLE      = 1'b1;
    localparam logic        CHIP_DISABLE     = 1'b0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched instruction with its address and misalignment tag
    typedef struct packed {
        logic [INST_ADDR_BUS_W-1:0] pc;
        logic [INST_BUS_W-1:0]      inst;
        logic                       misalign;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; clear wins over push/pop, head is zero when empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push = push & (~full | w_pop);
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push && !clear && !rst) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM and feeds decode from a prefetch FIFO.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROM_AW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_i,
    input  logic              flush_i,
    input  logic [31:0]       new_pc_i,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [31:0]       id_pc_o,
    output logic [31:0]       id_inst_o,
    output logic              id_misalign_o
);

    logic [31:0]  r_pc;
    logic         r_ce;
    logic         r_misalign_pend;

    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_slot;
    logic         w_fetch;
    logic         w_redirect;
    logic [31:0]  w_target;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    // Flush outranks branch when both redirect in the same cycle
    assign w_redirect = flush_i | branch_flag_i;
    assign w_target   = flush_i ? new_pc_i : branch_target_i;

    assign w_pop   = id_valid_o & id_ready_i;
    assign w_slot  = r_ce & (~w_full | w_pop);
    assign w_fetch = w_slot & ~w_redirect;

    assign rom_ce   = w_slot;
    assign rom_addr = r_pc[ROM_AW-1:0];

    assign w_push_entry.pc       = r_pc;
    assign w_push_entry.inst     = rom_inst;
    assign w_push_entry.misalign = r_misalign_pend;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_pc            <= RESET_PC;
            r_ce            <= CHIP_DISABLE;
            r_misalign_pend <= 1'b0;
        end else begin
            r_ce <= CHIP_ENABLE;
            if (w_redirect) begin
                r_pc            <= {w_target[31:2], 2'b00};
                r_misalign_pend <= |w_target[1:0];
            end else if (w_fetch) begin
                r_pc            <= r_pc + 32'd4;
                r_misalign_pend <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fetch),
        .pop   (w_pop),
        .clear (w_redirect),
        .din   (w_push_entry),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign id_valid_o    = ~w_empty;
    assign id_pc_o       = w_head.pc;
    assign id_inst_o     = w_head.inst;
    assign id_misalign_o = w_head.misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model, scoreboard monitor and directed scenarios.
module tb_inst_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [11:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_misalign_o;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4),
        .ROM_AW     (12)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce          (rom_ce),
        .rom_addr        (rom_addr),
        .rom_inst        (rom_inst),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .id_ready_i      (id_ready_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_misalign_o   (id_misalign_o)
    );

    logic [31:0] rom_mem [0:1023];
    assign rom_inst = rom_ce ? rom_mem[rom_addr[11:2]] : 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] m_pc   = 32'h0;
    bit          m_ce   = 1'b0;
    bit          m_mis  = 1'b0;
    bit          m_live = 1'b0;
    bit          m_popped = 1'b0;

    // Expected ROM word: 4 KB image aliased over the whole address space
    function automatic logic [31:0] rom_model(input logic [31:0] a);
        return 32'h1000_0000 + ((a % 32'd4096) / 32'd4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle interface checks, scoreboard pop on each accepted head
    always begin
        int   sz;
        bit   exp_pop;
        exp_t e;
        @(negedge clk);
        #2;
        if (m_live) begin
            sz      = exp_q.size();
            exp_pop = (sz != 0) && id_ready_i;
            chk("valid", 32'(id_valid_o), 32'(sz != 0));
            chk("rom_ce", 32'(rom_ce), 32'(m_ce && (sz < DEPTH || exp_pop)));
            chk("rom_addr", 32'(rom_addr), 32'(m_pc[11:0]));
            if (sz == 0) begin
                chk("empty_pc", id_pc_o, 32'h0);
                chk("empty_inst", id_inst_o, 32'h0);
                chk("empty_mis", 32'(id_misalign_o), 32'h0);
            end
            m_popped = 1'b0;
            if (id_valid_o && id_ready_i) begin
                if (sz == 0) begin
                    chk("pop_on_empty", 32'(id_valid_o), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", id_pc_o, e.pc);
                    chk("head_inst", id_inst_o, e.inst);
                    chk("head_mis", 32'(id_misalign_o), 32'(e.mis));
                    m_popped = 1'b1;
                end
            end
        end
    end

    // Reference model: advances the abstract fetch state across the coming edge
    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (rst) begin
            exp_q.delete();
            m_pc   = 32'h0;
            m_ce   = 1'b0;
            m_mis  = 1'b0;
            m_live = 1'b1;
        end else if (flush_i || branch_flag_i) begin
            exp_q.delete();
            m_pc  = flush_i ? new_pc_i : branch_target_i;
            m_mis = (m_pc % 4) != 0;
            m_pc  = m_pc - (m_pc % 4);
            m_ce  = 1'b1;
        end else begin
            if (m_ce && (m_popped || exp_q.size() < DEPTH)) begin
                e.pc   = m_pc;
                e.inst = rom_model(m_pc);
                e.mis  = m_mis;
                exp_q.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_mis = 1'b0;
            end
            m_ce = 1'b1;
        end
    end

    task automatic step(input bit r, input bit rd, input bit br, input logic [31:0] bt,
                        input bit fl, input logic [31:0] np);
        @(negedge clk);
        rst             = r;
        id_ready_i      = rd;
        branch_flag_i   = br;
        branch_target_i = bt;
        flush_i         = fl;
        new_pc_i        = np;
    endtask

    task automatic idle(input bit rd);
        step(1'b0, rd, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b1; id_ready_i = 1'b1; branch_flag_i = 1'b0; branch_target_i = 32'h0;
        flush_i = 1'b0; new_pc_i = 32'h0;

        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        // Reset release: first valid two edges later, then a steady stream
        idle(1'b1);
        idle(1'b1); #1 chk("rel_valid0", 32'(id_valid_o), 32'h0);
        idle(1'b1); #1 chk("rel_valid1", 32'(id_valid_o), 32'h1);
        chk("rel_pc0", id_pc_o, 32'h0);
        chk("rel_inst0", id_inst_o, 32'h1000_0000);
        repeat (8) idle(1'b1);

        // Decode stall from reset: four entries held, fetch parked at 16
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (11) idle(1'b0);
        #1 chk("stall_rom_ce", 32'(rom_ce), 32'h0);
        chk("stall_addr", 32'(rom_addr), 32'h10);
        for (int k = 0; k < 5; k++) begin
            idle(1'b1);
            #1 chk("drain_valid", 32'(id_valid_o), 32'h1);
            chk("drain_pc", id_pc_o, 32'(k * 4));
        end

        // Branch while full
        repeat (6) idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        idle(1'b0); #1 chk("br_bubble", 32'(id_valid_o), 32'h0);
        chk("br_addr", 32'(rom_addr), 32'h200);
        idle(1'b1); #1 chk("br_pc", id_pc_o, 32'h200);
        repeat (3) idle(1'b1);

        // Flush beats branch
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h100);
        idle(1'b1);
        idle(1'b1); #1 chk("flush_pc", id_pc_o, 32'h100);
        repeat (2) idle(1'b1);

        // Misaligned branch target
        step(1'b0, 1'b1, 1'b1, 32'h46, 1'b0, 32'h0);
        idle(1'b1);
        idle(1'b1); #1 chk("mis_pc", id_pc_o, 32'h44);
        chk("mis_flag", 32'(id_misalign_o), 32'h1);
        idle(1'b1); #1 chk("mis_next_pc", id_pc_o, 32'h48);
        chk("mis_next_flag", 32'(id_misalign_o), 32'h0);

        // Reset mid-stream with entries buffered
        repeat (3) idle(1'b1);
        repeat (2) idle(1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b1); #1 chk("rst_valid", 32'(id_valid_o), 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        chk("rst_mis", 32'(id_misalign_o), 32'h0);
        chk("rst_rom_ce", 32'(rom_ce), 32'h0);
        idle(1'b1);
        idle(1'b1); #1 chk("restart_pc", id_pc_o, 32'h0);
        chk("restart_valid", 32'(id_valid_o), 32'h1);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        idle(1'b1); #1 chk("wrap_a", 32'(rom_addr), 32'hFF8);
        idle(1'b1); #1 chk("wrap_b", 32'(rom_addr), 32'hFFC);
        idle(1'b1); #1 chk("wrap_c", 32'(rom_addr), 32'h000);
        repeat (3) idle(1'b1);

        // Random traffic
        repeat (800) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom(),
                 $urandom_range(0, 31) == 0, $urandom());
        end
        repeat (4) idle(1'b1);
        @(negedge clk); #4;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
